// File: rtl/wave_meter_pkg.sv
// Shared types and defaults for the waveform measurement stage.
// LUT_WIDTH mirrors the sample width produced by waveform_gen.
package wave_meter_pkg;
  localparam int LUT_WIDTH           = 16;
  localparam int METER_CNT_W_DEFAULT = 24;
  localparam int METER_HYST_DEFAULT  = 4;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, HIGH, LOW} meter_state_t;
endpackage

// File: rtl/hyst_crossing_det.sv
// Hysteresis classifier: level flags are combinational, rise/fall compare the
// current sample against the last side of the band that was actually reached.
module hyst_crossing_det #(
  parameter int DATA_WIDTH = 16,
  parameter int HYST       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic                         sample_valid,
  output logic                         is_high,
  output logic                         is_low,
  output logic                         rise,
  output logic                         fall
);
  localparam logic signed [DATA_WIDTH-1:0] HI_TH = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0] LO_TH = -HI_TH;

  logic above;

  assign is_high = (sample >= HI_TH);
  assign is_low  = (sample <= LO_TH);
  assign rise    = is_high & ~above;
  assign fall    = is_low & above;

  // In-band samples leave the remembered side untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       above <= 1'b0;
    else if (sample_valid && is_high) above <= 1'b1;
    else if (sample_valid && is_low)  above <= 1'b0;
  end
endmodule

// File: rtl/wave_meter.sv
// Period, high time and peak/valley meter for a signed sample stream,
// using rising-to-rising hysteresis crossings on accepted samples only.
module wave_meter
  import wave_meter_pkg::*;
#(
  parameter int DATA_WIDTH = LUT_WIDTH,
  parameter int CNT_W      = METER_CNT_W_DEFAULT,
  parameter int HYST       = METER_HYST_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  input  logic                         meas_en_i,
  input  logic                         clear_i,
  output logic [CNT_W-1:0]             period_o,
  output logic [CNT_W-1:0]             high_time_o,
  output logic signed [DATA_WIDTH-1:0] peak_o,
  output logic signed [DATA_WIDTH-1:0] valley_o,
  output logic                         meas_valid_o,
  output logic                         timeout_o
);
  // One below all-ones: the next increment would saturate the counter.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  meter_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, hcnt, high_reg;
  logic signed [DATA_WIDTH-1:0] run_max, run_min;
  logic is_high, is_low, rise, fall;
  logic cnt_sat, start_per, load_res, to_hit, grab_high, track;

  hyst_crossing_det #(.DATA_WIDTH(DATA_WIDTH), .HYST(HYST)) u_det (
    .clk(clk), .rst_n(rst_n), .sample(sample_i), .sample_valid(sample_valid_i),
    .is_high(is_high), .is_low(is_low), .rise(rise), .fall(fall)
  );

  assign cnt_sat = (cnt >= CNT_LAST);

  always_comb begin
    state_nxt = state;
    start_per = 1'b0;
    load_res  = 1'b0;
    to_hit    = 1'b0;
    grab_high = 1'b0;
    track     = 1'b0;
    if (clear_i) begin
      state_nxt = meas_en_i ? ARM : IDLE;
    end else if (!meas_en_i) begin
      state_nxt = IDLE;
    end else if (sample_valid_i) begin
      case (state)
        IDLE:      state_nxt = ARM;
        ARM:       if (is_low) state_nxt = WAIT_RISE;
        WAIT_RISE: if (is_high) begin
          start_per = 1'b1;
          state_nxt = HIGH;
        end
        HIGH: begin
          track = 1'b1;
          if (cnt_sat) begin
            to_hit    = 1'b1;
            state_nxt = ARM;
          end else if (fall) begin
            grab_high = 1'b1;
            state_nxt = LOW;
          end
        end
        LOW: begin
          // A rising crossing closes the period even on the last count.
          if (rise) begin
            load_res  = 1'b1;
            start_per = 1'b1;
            state_nxt = HIGH;
          end else begin
            track = 1'b1;
            if (cnt_sat) begin
              to_hit    = 1'b1;
              state_nxt = ARM;
            end
          end
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      high_reg     <= '0;
      run_max      <= '0;
      run_min      <= '0;
      period_o     <= '0;
      high_time_o  <= '0;
      peak_o       <= '0;
      valley_o     <= '0;
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      meas_valid_o <= load_res;
      if (clear_i) begin
        cnt         <= '0;
        hcnt        <= '0;
        high_reg    <= '0;
        run_max     <= '0;
        run_min     <= '0;
        period_o    <= '0;
        high_time_o <= '0;
        peak_o      <= '0;
        valley_o    <= '0;
        timeout_o   <= 1'b0;
      end else if (!meas_en_i) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (sample_valid_i) begin
        if (load_res) begin
          period_o    <= cnt;
          high_time_o <= high_reg;
          peak_o      <= run_max;
          valley_o    <= run_min;
        end
        if (grab_high) high_reg <= hcnt;
        if (start_per) begin
          cnt     <= CNT_W'(1);
          hcnt    <= CNT_W'(1);
          run_max <= sample_i;
          run_min <= sample_i;
        end else if (to_hit) begin
          cnt       <= '0;
          hcnt      <= '0;
          timeout_o <= 1'b1;
        end else if (track) begin
          cnt <= cnt + 1'b1;
          if (state == HIGH) hcnt <= hcnt + 1'b1;
          if (sample_i > run_max) run_max <= sample_i;
          if (sample_i < run_min) run_min <= sample_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_meter.sv
// Randomised bench for wave_meter against a sample-history reference model.
module tb_wave_meter;
  localparam int DW  = 16;
  localparam int CW  = 8;
  localparam int H   = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [DW-1:0] sample = '0;
  logic sample_valid = 1'b0, meas_en = 1'b0, clear = 1'b0;
  logic [CW-1:0] period, high_time;
  logic signed [DW-1:0] peak, valley;
  logic meas_valid, timeout;

  int checks = 0, passed = 0;

  wave_meter #(.DATA_WIDTH(DW), .CNT_W(CW), .HYST(H)) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample), .sample_valid_i(sample_valid),
    .meas_en_i(meas_en), .clear_i(clear), .period_o(period), .high_time_o(high_time),
    .peak_o(peak), .valley_o(valley), .meas_valid_o(meas_valid), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: keeps every accepted sample since the last rising crossing.
  typedef enum {M_OFF, M_NEED_LOW, M_NEED_RISE, M_MEAS} mphase_t;
  mphase_t ph;
  int per[$];
  bit pol_high;
  int fall_pos;
  int e_period, e_high, e_peak, e_valley;
  bit e_mv, e_to;

  function automatic void model_reset();
    ph = M_OFF; per.delete(); pol_high = 0; fall_pos = 0;
    e_period = 0; e_high = 0; e_peak = 0; e_valley = 0; e_mv = 0; e_to = 0;
  endfunction

  function automatic void model_step(input int s, input bit v, input bit en, input bit clr);
    int mx, mn;
    e_mv = 0;
    if (clr) begin
      e_period = 0; e_high = 0; e_peak = 0; e_valley = 0; e_to = 0;
      ph = en ? M_NEED_LOW : M_OFF; per.delete();
    end else if (!en) begin
      ph = M_OFF; per.delete();
    end else if (v) begin
      case (ph)
        M_OFF:       ph = M_NEED_LOW;
        M_NEED_LOW:  if (s <= -H) ph = M_NEED_RISE;
        M_NEED_RISE: if (s >= H) begin ph = M_MEAS; per = '{s}; pol_high = 1; end
        M_MEAS: begin
          if (!pol_high && s >= H) begin
            mx = per[0]; mn = per[0];
            foreach (per[k]) begin
              if (per[k] > mx) mx = per[k];
              if (per[k] < mn) mn = per[k];
            end
            e_period = per.size(); e_high = fall_pos; e_peak = mx; e_valley = mn;
            e_mv = 1; per = '{s}; pol_high = 1;
          end else begin
            per.push_back(s);
            if (pol_high && s <= -H) begin fall_pos = per.size() - 1; pol_high = 0; end
            if (per.size() >= MAX) begin e_to = 1; ph = M_NEED_LOW; per.delete(); end
          end
        end
        default: ph = M_OFF;
      endcase
    end
  endfunction

  task automatic step(input int s, input bit v, input bit en, input bit clr);
    sample = DW'(s); sample_valid = v; meas_en = en; clear = clr;
    model_step(s, v, en, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (period !== '0 || high_time !== '0 || peak !== '0 || valley !== '0 ||
        meas_valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset: got p=%0d h=%0d pk=%0d vl=%0d mv=%0b to=%0b, want all 0",
               period, high_time, peak, valley, meas_valid, timeout);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_square(input int hi, input int lo, input int amp, input int nper);
    int p, nstrobe, last;
    p = hi + lo; nstrobe = 0; last = -1;
    step(0, 1, 0, 0);
    for (int i = 0; i < nper * p + lo + 1; i++) begin
      step(((i % p) < lo) ? -amp : amp, 1, 1, 0);
      checks++;
      if (meas_valid !== e_mv || timeout !== e_to)
        $display("FAIL square_flags i=%0d: got mv=%0b to=%0b, want %0b %0b", i, meas_valid, timeout, e_mv, e_to);
      else passed++;
      if (e_mv || meas_valid) begin
        checks++;
        if (period !== CW'(e_period) || high_time !== CW'(e_high) || int'(peak) !== e_peak || int'(valley) !== e_valley)
          $display("FAIL square_result i=%0d: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", i,
                   period, high_time, peak, valley, e_period, e_high, e_peak, e_valley);
        else passed++;
      end
      if (meas_valid) begin
        checks++;
        if (last < 0) begin
          if (period !== CW'(p) || high_time !== CW'(hi) || int'(peak) !== amp || int'(valley) !== -amp || i !== lo + p)
            $display("FAIL square_first: got i=%0d p=%0d h=%0d pk=%0d vl=%0d, want i=%0d p=%0d h=%0d pk=%0d vl=%0d",
                     i, period, high_time, peak, valley, lo + p, p, hi, amp, -amp);
          else passed++;
        end else begin
          if (i - last !== p) $display("FAIL square_spacing: got %0d cycles, want %0d", i - last, p);
          else passed++;
        end
        last = i; nstrobe++;
      end
    end
    checks++;
    if (nstrobe !== nper) $display("FAIL square_count: got %0d strobes, want %0d", nstrobe, nper);
    else passed++;
  endtask

  task automatic test_valid_gaps();
    int j, nstrobe;
    bit v;
    j = 0; nstrobe = 0;
    step(0, 1, 0, 0);
    for (int c = 0; c < 2 * (3 * 64 + 33); c++) begin
      v = (c % 2) == 0;
      if (v) begin
        step(((j % 64) < 32) ? -700 : 700, 1, 1, 0);
        j++;
      end else begin
        step(int'($urandom_range(4000)) - 2000, 0, 1, 0);
      end
      checks++;
      if (meas_valid !== e_mv || timeout !== e_to)
        $display("FAIL gaps_flags c=%0d: got mv=%0b to=%0b, want %0b %0b", c, meas_valid, timeout, e_mv, e_to);
      else passed++;
      if (meas_valid) begin
        nstrobe++;
        checks++;
        if (period !== CW'(64) || high_time !== CW'(32) || int'(peak) !== 700 || int'(valley) !== -700)
          $display("FAIL gaps_result: got %0d/%0d/%0d/%0d, want 64/32/700/-700", period, high_time, peak, valley);
        else passed++;
      end
    end
    checks++;
    if (nstrobe !== 3) $display("FAIL gaps_count: got %0d strobes, want 3", nstrobe);
    else passed++;
  endtask

  task automatic test_random();
    int len, got, s, nstrobe;
    bit v;
    nstrobe = 0;
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int ph_i = 0; ph_i < 12; ph_i++) begin
      len = $urandom_range(40, 3);
      got = 0;
      while (got < len) begin
        v = ($urandom_range(3) != 0);
        if (got > 0 && $urandom_range(4) == 0) s = int'($urandom_range(6)) - 3;
        else s = int'($urandom_range(2000, H));
        if (ph_i % 2 == 0) s = (s >= H) ? -s : s;
        step(s, v, 1, 0);
        if (v) got++;
        checks++;
        if (meas_valid !== e_mv || timeout !== e_to)
          $display("FAIL random_flags: got mv=%0b to=%0b, want %0b %0b", meas_valid, timeout, e_mv, e_to);
        else passed++;
        if (e_mv || meas_valid) begin
          checks++;
          if (period !== CW'(e_period) || high_time !== CW'(e_high) || int'(peak) !== e_peak || int'(valley) !== e_valley)
            $display("FAIL random_result: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d",
                     period, high_time, peak, valley, e_period, e_high, e_peak, e_valley);
          else passed++;
        end
        if (meas_valid) nstrobe++;
      end
    end
    checks++;
    if (nstrobe !== 5) $display("FAIL random_count: got %0d strobes, want 5", nstrobe);
    else passed++;
  endtask

  task automatic test_timeout_clear();
    step(0, 1, 1, 1);
    repeat (3)  step(-1000, 1, 1, 0);
    repeat (10) step(1000, 1, 1, 0);
    repeat (10) step(-1000, 1, 1, 0);
    step(1000, 1, 1, 0);
    checks++;
    if (meas_valid !== 1'b1 || period !== CW'(20) || high_time !== CW'(10) || int'(peak) !== 1000 || int'(valley) !== -1000)
      $display("FAIL pre_timeout: got mv=%0b %0d/%0d/%0d/%0d, want 1 20/10/1000/-1000",
               meas_valid, period, high_time, peak, valley);
    else passed++;
    for (int k = 1; k <= 254; k++) begin
      step(int'($urandom_range(6)) - 3, 1, 1, 0);
      checks++;
      if (meas_valid !== 1'b0 || timeout !== (k >= 254) || timeout !== e_to)
        $display("FAIL timeout k=%0d: got mv=%0b to=%0b, want mv=0 to=%0b", k, meas_valid, timeout, k >= 254);
      else passed++;
    end
    step(0, 1, 1, 1);
    checks++;
    if (period !== '0 || high_time !== '0 || peak !== '0 || valley !== '0 || timeout !== 1'b0 || meas_valid !== 1'b0)
      $display("FAIL clear: got %0d/%0d/%0d/%0d to=%0b mv=%0b, want all 0", period, high_time, peak, valley, timeout, meas_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int first;
    step(0, 1, 0, 0);
    for (int i = 0; i < 116; i++) step(((i % 64) < 32) ? -500 : 500, 1, 1, 0);
    repeat (5) step(500, 1, 0, 0);
    checks++;
    if (period !== CW'(64) || high_time !== CW'(32) || meas_valid !== 1'b0 || period !== CW'(e_period))
      $display("FAIL en_hold: got p=%0d h=%0d mv=%0b, want 64 32 0", period, high_time, meas_valid);
    else passed++;
    for (int i = 0; i < 40; i++) step(((i % 64) < 32) ? -500 : 500, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (period !== '0 || high_time !== '0 || peak !== '0 || valley !== '0 || meas_valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL async_reset: got %0d/%0d/%0d/%0d mv=%0b to=%0b, want all 0", period, high_time, peak, valley, meas_valid, timeout);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int i = 0; i < 170; i++) begin
      step(((i % 64) < 32) ? -800 : 800, 1, 1, 0);
      checks++;
      if (meas_valid !== e_mv || period !== CW'(e_period) || int'(peak) !== e_peak)
        $display("FAIL post_reset i=%0d: got mv=%0b p=%0d pk=%0d, want %0b %0d %0d", i, meas_valid, period, peak, e_mv, e_period, e_peak);
      else passed++;
      if (meas_valid && first < 0) first = i;
    end
    checks++;
    if (first !== 96) $display("FAIL post_reset_first: got strobe at %0d, want 96", first);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_square(32, 32, 1000, 3);
    test_square(19, 45, 1000, 3);
    test_valid_gaps();
    test_random();
    test_timeout_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
